// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared types and helpers for the push-button debouncer.
//                - btn_state_e : per-channel debounce FSM state (2-bit)
//                - cnt_width() : counter width able to hold 0..max_val
//  Revision    : 1.0  initial release
// ============================================================================
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_e;

  // Width of a counter that must represent every value 0..max_val.
  // Never returns 0 so a degenerate parameter still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_ch
//  Description : One push-button channel: 2-flop synchroniser, stable-count
//                debounce FSM, registered press/release strobes and an
//                optional auto-repeat strobe.
//  Optional    : BTN_DEBOUNCE_REPEAT_EN - builds the auto-repeat counter;
//                when undefined repeat_o is tied to 0.
//  Ports       : clk       in  system clock (rising edge)
//                rst       in  synchronous active-high reset
//                btn_i     in  raw asynchronous button input
//                level_o   out debounced level
//                press_o   out one-cycle strobe on level rise
//                release_o out one-cycle strobe on level fall
//                repeat_o  out one-cycle auto-repeat strobe
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEB_CYC = 50000,
  parameter int unsigned RPT_DLY = 25000000,
  parameter int unsigned RPT_PER = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int unsigned c_cnt_w = cnt_width(DEB_CYC);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEB_CYC);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  logic               s1_q, s2_q;
  btn_state_e         state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               press_q, press_d;
  logic               release_q, release_d;

  // Debounce FSM. The counter never passes c_cnt_max: reaching it forces a
  // state change that reloads it, so it saturates by construction.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: begin
        cnt_d = '0;
        if (s2_q) begin
          state_d = PRESS_PEND;
          cnt_d   = c_cnt_one;
        end
      end
      PRESS_PEND: begin
        if (!s2_q) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == c_cnt_max) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end
      PRESSED: begin
        cnt_d = '0;
        if (!s2_q) begin
          state_d = RELEASE_PEND;
          cnt_d   = c_cnt_one;
        end
      end
      RELEASE_PEND: begin
        if (s2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == c_cnt_max) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= RELEASED;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= btn_i;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Level stays high while a release is still being qualified.
  assign level_o   = (state_q == PRESSED) || (state_q == RELEASE_PEND);
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int unsigned c_rpt_max = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int unsigned c_rpt_w   = cnt_width(c_rpt_max);

  logic [c_rpt_w-1:0] rpt_cnt_q, rpt_cnt_d, rpt_cnt_inc, rpt_target;
  logic               rpt_first_q, rpt_first_d;
  logic               rpt_en_q, rpt_en_d;
  logic               rpt_q, rpt_d;

  // First interval is the initial delay, every later one the period.
  assign rpt_target  = rpt_first_q ? c_rpt_w'(RPT_DLY) : c_rpt_w'(RPT_PER);
  assign rpt_cnt_inc = rpt_cnt_q + c_rpt_w'(1);

  // Repeat only runs while the channel remains in PRESSED; leaving it
  // (even to a RELEASE_PEND that later bounces back) disarms until the
  // next press strobe.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    rpt_en_d    = rpt_en_q;
    rpt_d       = 1'b0;
    if (press_d) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
      rpt_en_d    = 1'b1;
    end else if (state_d != PRESSED) begin
      rpt_cnt_d = '0;
      rpt_en_d  = 1'b0;
    end else if (rpt_en_q) begin
      if (rpt_cnt_inc == rpt_target) begin
        rpt_d       = 1'b1;
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d = rpt_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b0;
      rpt_en_q    <= 1'b0;
      rpt_q       <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
      rpt_en_q    <= rpt_en_d;
      rpt_q       <= rpt_d;
    end
  end

  assign repeat_o = rpt_q;
`else
  localparam int unsigned c_unused_rpt = RPT_DLY + RPT_PER;
  assign repeat_o = 1'b0;
`endif

endmodule : btn_debounce_ch
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Multi-channel push-button front end. N_CH independent
//                debounce channels producing a clean level plus press,
//                release and optional auto-repeat strobes.
//  Optional    : BTN_DEBOUNCE_REPEAT_EN - enables the auto-repeat strobe;
//                when undefined btn_repeat is constant 0.
//  Ports       : clk         in  system clock (rising edge)
//                rst         in  synchronous active-high reset
//                btn         in  [N_CH] raw bouncing button inputs
//                btn_level   out [N_CH] debounced levels
//                btn_press   out [N_CH] press strobes
//                btn_release out [N_CH] release strobes
//                btn_repeat  out [N_CH] auto-repeat strobes
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned DEB_CYC = 50000,
  parameter int unsigned RPT_DLY = 25000000,
  parameter int unsigned RPT_PER = 5000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_repeat
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .DEB_CYC (DEB_CYC),
      .RPT_DLY (RPT_DLY),
      .RPT_PER (RPT_PER)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_i     (btn[i]),
      .level_o   (btn_level[i]),
      .press_o   (btn_press[i]),
      .release_o (btn_release[i]),
      .repeat_o  (btn_repeat[i])
    );
  end

endmodule : btn_debounce
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_debounce
//  Description : Self-checking bench for btn_debounce. A per-channel
//                reference model (run-length of samples disagreeing with the
//                current level, plus a hold-age for repeat) predicts every
//                output each cycle; directed scenarios add latency checks.
//  Optional    : BTN_DEBOUNCE_REPEAT_EN - expects repeat pulses when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_btn_debounce;

  localparam int N_CH    = 4;
  localparam int DEB_CYC = 4;
  localparam int RPT_DLY = 10;
  localparam int RPT_PER = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] btn;
  logic [N_CH-1:0] btn_level, btn_press, btn_release, btn_repeat;

  always #5 clk = ~clk;

  btn_debounce #(
    .N_CH    (N_CH),
    .DEB_CYC (DEB_CYC),
    .RPT_DLY (RPT_DLY),
    .RPT_PER (RPT_PER)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_repeat  (btn_repeat)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  bit              m_s1 [N_CH];
  bit              m_s2 [N_CH];
  bit              m_lvl[N_CH];
  bit              m_held[N_CH];
  int              m_run[N_CH];
  int              m_age[N_CH];
  logic [N_CH-1:0] e_lvl, e_press, e_rel, e_rpt;

  // Level flips after DEB_CYC+1 consecutive synchronised samples that
  // disagree with it. Repeat fires at ages RPT_DLY, RPT_DLY+RPT_PER, ...
  // counted from the press, for as long as no release sample was seen.
  task automatic model_step(input bit r, input logic [N_CH-1:0] b);
    for (int i = 0; i < N_CH; i++) begin
      e_press[i] = 1'b0;
      e_rel[i]   = 1'b0;
      e_rpt[i]   = 1'b0;
      if (r) begin
        m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0;
        m_run[i] = 0; m_held[i] = 0; m_age[i] = 0;
      end else begin
        if (m_s2[i] != m_lvl[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_lvl[i] && !m_s2[i]) m_held[i] = 0;
        if (m_run[i] == DEB_CYC + 1) begin
          m_lvl[i] = !m_lvl[i];
          m_run[i] = 0;
          if (m_lvl[i]) begin
            e_press[i] = 1'b1;
            m_held[i]  = 1;
            m_age[i]   = 0;
          end else begin
            e_rel[i] = 1'b1;
          end
        end else if (m_lvl[i] && m_held[i]) begin
          m_age[i]++;
          if (m_age[i] >= RPT_DLY && ((m_age[i] - RPT_DLY) % RPT_PER) == 0)
            e_rpt[i] = 1'b1;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = b[i];
      end
      e_lvl[i] = m_lvl[i];
    end
`ifndef BTN_DEBOUNCE_REPEAT_EN
    e_rpt = '0;
`endif
  endtask

  task automatic tick(input bit r, input logic [N_CH-1:0] b);
    rst = r;
    btn = b;
    @(posedge clk);
    model_step(r, b);
    #1;
    check("level",   btn_level,   e_lvl);
    check("press",   btn_press,   e_press);
    check("release", btn_release, e_rel);
    check("repeat",  btn_repeat,  e_rpt);
    check("press_and_release", btn_press & btn_release, '0);
  endtask

  int              t_hit;
  int              n_hit;
  int              n_rel;
  int              denom;
  logic [N_CH-1:0] cur;

  initial begin
    rst = 1'b1;
    btn = '0;

    // Reset held with all buttons pressed, then fresh press after release
    for (int k = 0; k < 3; k++) tick(1'b1, 4'hF);
    t_hit = -1;
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 4'hF);
      if (btn_press == 4'hF && t_hit < 0) t_hit = k;
    end
    check("reset_press_cycle", t_hit, 6);
    for (int k = 0; k < 12; k++) tick(1'b0, 4'h0);

    // Clean press on channel 2
    t_hit = -1;
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 4'b0100);
      if (btn_press[2] && t_hit < 0) t_hit = k;
    end
    check("clean_press_cycle", t_hit, 6);

    // Release on channel 3 after a stable press
    for (int k = 0; k < 10; k++) tick(1'b0, 4'b1100);
    t_hit = -1;
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 4'b0100);
      if (btn_release[3] && t_hit < 0) t_hit = k;
    end
    check("release_cycle", t_hit, 6);

    // Bounce on channel 1: 1,0,1,0 then held high
    n_hit = 0; n_rel = 0; t_hit = -1;
    for (int k = 0; k < 18; k++) begin
      cur = 4'b0100;
      cur[1] = (k < 4) ? ((k % 2) == 0) : 1'b1;
      tick(1'b0, cur);
      if (btn_press[1]) begin n_hit++; t_hit = k; end
      if (btn_release[1]) n_rel++;
    end
    check("bounce_press_count", n_hit, 1);
    check("bounce_press_cycle", t_hit, 10);
    check("bounce_release_count", n_rel, 0);
    for (int k = 0; k < 12; k++) tick(1'b0, 4'h0);

    // Auto-repeat on channel 2: first pulse RPT_DLY after the press
    t_hit = -1; n_hit = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1'b0, 4'b0100);
      if (btn_press[2]) t_hit = k;
      if (btn_repeat[2]) n_hit++;
    end
`ifdef BTN_DEBOUNCE_REPEAT_EN
    check("repeat_count", n_hit, 5);
`else
    check("repeat_count", n_hit, 0);
`endif
    n_hit = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 4'h0);
      if (btn_repeat[2]) n_hit++;
    end
    check("repeat_after_release", n_hit, 0);

    // Glitch shorter than DEB_CYC on channel 0
    n_hit = 0;
    for (int k = 0; k < 14; k++) begin
      tick(1'b0, (k < 3) ? 4'b0001 : 4'b0000);
      if (btn_level[0] | btn_press[0] | btn_release[0]) n_hit++;
    end
    check("glitch_activity", n_hit, 0);

    // Randomized phase with varying bounce density and occasional resets
    cur = '0;
    denom = 6;
    for (int k = 0; k < 4000; k++) begin
      if ((k % 200) == 0) begin
        case ($urandom_range(2))
          0: denom = 3;
          1: denom = 6;
          default: denom = 25;
        endcase
      end
      for (int i = 0; i < N_CH; i++)
        if ($urandom_range(denom - 1) == 0) cur[i] = ~cur[i];
      tick($urandom_range(399) == 0, cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_btn_debounce
`default_nettype wire
